// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage next-PC scheduler and its BTB.
package fetch_pkg;

  localparam int DATA_SIZE = 32;
  // Tag is kept at the widest possible size; narrower tags are zero-extended.
  localparam int TAG_W     = DATA_SIZE - 2;

  localparam logic [DATA_SIZE-1:0] RESET_PC_DEF = 32'h0fff_fffc;
  localparam logic [DATA_SIZE-1:0] PC_STEP      = 32'd4;

  localparam logic [1:0] CNT_WEAK_T   = 2'b10;
  localparam logic [1:0] CNT_STRONG_T = 2'b11;
  localparam logic [1:0] CNT_RST      = 2'b01;

  typedef enum logic {RUN, HOLD} state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [DATA_SIZE-1:0] target;
    logic [1:0]           cnt;
  } btb_entry_t;

  // Two-bit saturating direction counter.
  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != 2'b11) begin
      res = cnt + 2'b01;
    end else if (!taken && cnt != 2'b00) begin
      res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/next_pc_ctrl_if.sv
// Fetch-side bus of the next-PC scheduler: PC feedback, stalls, EXE resolution, next PC.
interface next_pc_ctrl_if;
  import fetch_pkg::*;

  logic [DATA_SIZE-1:0] pc_cur;
  logic                 Istall;
  logic                 Dstall;
  logic                 exe_valid;
  logic                 exe_is_jump;
  logic [DATA_SIZE-1:0] exe_pc;
  logic                 exe_taken;
  logic [DATA_SIZE-1:0] exe_target;
  logic                 exe_pred_taken;
  logic [DATA_SIZE-1:0] exe_pred_target;
  logic [DATA_SIZE-1:0] pc_next;
  logic                 pred_taken;
  logic [DATA_SIZE-1:0] pred_target;
  logic                 flush;

  modport master (
    output pc_cur, Istall, Dstall, exe_valid, exe_is_jump, exe_pc, exe_taken,
           exe_target, exe_pred_taken, exe_pred_target,
    input  pc_next, pred_taken, pred_target, flush
  );

  modport slave (
    input  pc_cur, Istall, Dstall, exe_valid, exe_is_jump, exe_pc, exe_taken,
           exe_target, exe_pred_taken, exe_pred_target,
    output pc_next, pred_taken, pred_target, flush
  );
endinterface

// File: rtl/next_pc_ctrl_btb_bht.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup, one
// synchronous update port. Lookup sees pre-update contents on a same-cycle write.
module btb_bht
  import fetch_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] lk_pc,
  output logic                 lk_taken,
  output logic [DATA_SIZE-1:0] lk_target,
  input  logic                 upd_en,
  input  logic [DATA_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic                 upd_jump,
  input  logic [DATA_SIZE-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam btb_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_RST};

  btb_entry_t entry_reg [BTB_ENTRIES];
  btb_entry_t entry_next;
  logic       wr_any;
  logic [BTB_ENTRIES-1:0] wr_en;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  btb_entry_t       lk_entry;
  logic             lk_hit;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  btb_entry_t       upd_cur;
  logic             upd_hit;

  assign lk_idx   = lk_pc[2 +: IDX_W];
  assign lk_tag   = TAG_W'(lk_pc >> (2 + IDX_W));
  assign lk_entry = entry_reg[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign lk_taken  = lk_hit && lk_entry.cnt[1];
  assign lk_target = lk_hit ? lk_entry.target : '0;

  assign upd_idx = upd_pc[2 +: IDX_W];
  assign upd_tag = TAG_W'(upd_pc >> (2 + IDX_W));
  assign upd_cur = entry_reg[upd_idx];
  assign upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);

  always_comb begin
    entry_next = upd_cur;
    wr_any     = 1'b0;
    if (upd_en) begin
      if (upd_hit) begin
        wr_any         = 1'b1;
        entry_next.cnt = upd_jump ? CNT_STRONG_T : cnt_update(upd_cur.cnt, upd_taken);
        if (upd_taken) begin
          entry_next.target = upd_target;
        end
      end else if (upd_taken) begin
        wr_any     = 1'b1;
        entry_next = '{valid: 1'b1, tag: upd_tag, target: upd_target,
                       cnt: (upd_jump ? CNT_STRONG_T : CNT_WEAK_T)};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      assign wr_en[gi] = wr_any && (upd_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg[gi] <= ENTRY_RST;
        end else if (wr_en[gi]) begin
          entry_reg[gi] <= entry_next;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/next_pc_ctrl.sv
// Next-PC scheduler: chooses PC+4, BTB prediction or EXE redirect, holds
// redirects across pipeline stalls and raises the IF/ID flush.
module next_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int                   BTB_ENTRIES = 16,
  parameter logic [DATA_SIZE-1:0] RESET_PC    = RESET_PC_DEF
) (
  input logic           clk,
  input logic           rst,
  next_pc_ctrl_if.slave bus
);

  state_t               state_reg;
  logic [DATA_SIZE-1:0] redir_pc_reg;

  logic                 stall;
  logic                 mispredict;
  logic [DATA_SIZE-1:0] correct_pc;
  logic                 lk_taken;
  logic [DATA_SIZE-1:0] lk_target;
  logic                 btb_upd_en;
  logic [DATA_SIZE-1:0] pc_next_c;
  logic                 flush_c;

  assign stall = bus.Istall | bus.Dstall;

  assign mispredict = bus.exe_valid &&
                      ((bus.exe_taken != bus.exe_pred_taken) ||
                       (bus.exe_taken && (bus.exe_target != bus.exe_pred_target)));

  assign correct_pc = bus.exe_taken ? bus.exe_target : (bus.exe_pc + PC_STEP);

  // Stalled cycles never update, so a resolution held in HOLD is written
  // exactly once, on the release cycle, from its still-stable EXE inputs.
  assign btb_upd_en = bus.exe_valid && !stall;

  btb_bht #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lk_pc     (bus.pc_cur),
    .lk_taken  (lk_taken),
    .lk_target (lk_target),
    .upd_en    (btb_upd_en),
    .upd_pc    (bus.exe_pc),
    .upd_taken (bus.exe_taken),
    .upd_jump  (bus.exe_is_jump),
    .upd_target(bus.exe_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      redir_pc_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (mispredict && stall) begin
            state_reg    <= HOLD;
            redir_pc_reg <= correct_pc;
          end
        end
        HOLD: begin
          if (!stall) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  // A redirect (pending or fresh) always wins over the BTB prediction.
  always_comb begin
    pc_next_c = lk_taken ? lk_target : (bus.pc_cur + PC_STEP);
    flush_c   = 1'b0;
    if (rst) begin
      pc_next_c = RESET_PC + PC_STEP;
    end else if (state_reg == HOLD) begin
      pc_next_c = redir_pc_reg;
      flush_c   = !stall;
    end else if (mispredict) begin
      pc_next_c = correct_pc;
      flush_c   = !stall;
    end
  end

  assign bus.pc_next     = pc_next_c;
  assign bus.flush       = flush_c;
  assign bus.pred_taken  = rst ? 1'b0 : lk_taken;
  assign bus.pred_target = rst ? '0 : lk_target;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Cycle-scripted bench for next_pc_ctrl: a table of per-cycle inputs and
// hand-computed outputs, then a reset-during-HOLD sequence.
module tb_next_pc_ctrl;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        ist;
    logic        dst;
    logic        ev;
    logic        jmp;
    logic [31:0] epc;
    logic        etk;
    logic [31:0] etgt;
    logic        eptk;
    logic [31:0] eptgt;
    logic [31:0] x_pcn;
    logic        x_ptk;
    logic [31:0] x_ptgt;
    logic        x_fl;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t tbl[$];

  next_pc_ctrl_if bus ();

  next_pc_ctrl #(
    .BTB_ENTRIES(16),
    .RESET_PC   (32'h0fff_fffc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] pc, input logic ist, input logic dst,
                     input logic ev, input logic jmp, input logic [31:0] epc, input logic etk,
                     input logic [31:0] etgt, input logic eptk, input logic [31:0] eptgt,
                     input logic [31:0] xpcn, input logic xptk, input logic [31:0] xptgt,
                     input logic xfl);
    vec_t v;
    v = '{rst: r, pc: pc, ist: ist, dst: dst, ev: ev, jmp: jmp, epc: epc, etk: etk,
          etgt: etgt, eptk: eptk, eptgt: eptgt, x_pcn: xpcn, x_ptk: xptk,
          x_ptgt: xptgt, x_fl: xfl};
    tbl.push_back(v);
  endtask

  // Plain fetch cycle: no stall, nothing resolving.
  task automatic add_seq(input logic [31:0] pc, input logic [31:0] xpcn,
                         input logic xptk, input logic [31:0] xptgt);
    add(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
        xpcn, xptk, xptgt, 1'b0);
  endtask

  // Drive one cycle's inputs just after a rising edge, check mid-cycle, then clock.
  task automatic apply_vec(input vec_t v, input string tag);
    rst                 = v.rst;
    bus.pc_cur          = v.pc;
    bus.Istall          = v.ist;
    bus.Dstall          = v.dst;
    bus.exe_valid       = v.ev;
    bus.exe_is_jump     = v.jmp;
    bus.exe_pc          = v.epc;
    bus.exe_taken       = v.etk;
    bus.exe_target      = v.etgt;
    bus.exe_pred_taken  = v.eptk;
    bus.exe_pred_target = v.eptgt;
    @(negedge clk);
    $display("%s pc_cur=%h stall=%b%b exe=%b pc_next=%h pred=%b/%h flush=%b",
             tag, v.pc, v.ist, v.dst, v.ev, bus.pc_next, bus.pred_taken,
             bus.pred_target, bus.flush);
    chk({tag, " pc_next"},     bus.pc_next,            v.x_pcn);
    chk({tag, " pred_taken"},  32'(bus.pred_taken),    32'(v.x_ptk));
    chk({tag, " pred_target"}, bus.pred_target,        v.x_ptgt);
    chk({tag, " flush"},       32'(bus.flush),         32'(v.x_fl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t h;
    n_checks = 0;
    n_fail   = 0;

    // rst pc        ist  dst  ev   jmp  exe_pc        tk   target        ptk  ptarget       | pc_next      ptk  ptgt          flush
    add(1, 32'h0fff_fffc, 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,           32'h1000_0000, 0, 32'h0,         0);
    add_seq(32'h0fff_fffc, 32'h1000_0000, 0, 32'h0);
    add_seq(32'h1000_0000, 32'h1000_0004, 0, 32'h0);
    add_seq(32'h1000_0004, 32'h1000_0008, 0, 32'h0);
    add_seq(32'h1000_0008, 32'h1000_000c, 0, 32'h0);
    add_seq(32'h1000_000c, 32'h1000_0010, 0, 32'h0);
    add_seq(32'h1000_0010, 32'h1000_0014, 0, 32'h0);
    // Branch at 0x10 taken, predicted not-taken: flush + allocate (cnt 10).
    add(0, 32'h1000_0018, 0, 0, 1, 0, 32'h1000_0010, 1, 32'h1000_0100, 0, 32'h0,         32'h1000_0100, 0, 32'h0,         1);
    add_seq(32'h1000_0100, 32'h1000_0104, 0, 32'h0);
    add_seq(32'h1000_0010, 32'h1000_0100, 1, 32'h1000_0100);
    // Two not-taken resolutions: 10 -> 01 (mispredict) -> 00.
    add(0, 32'h1000_0108, 0, 0, 1, 0, 32'h1000_0010, 0, 32'h0,         1, 32'h1000_0100,   32'h1000_0014, 0, 32'h0,         1);
    add_seq(32'h1000_0010, 32'h1000_0014, 0, 32'h1000_0100);
    add(0, 32'h1000_0014, 0, 0, 1, 0, 32'h1000_0010, 0, 32'h0,         0, 32'h1000_0100,   32'h1000_0018, 0, 32'h0,         0);
    add_seq(32'h1000_0010, 32'h1000_0014, 0, 32'h1000_0100);
    // Taken mispredict under a 3-cycle Dstall; released on the 4th cycle.
    add(0, 32'h1000_0018, 0, 1, 1, 0, 32'h1000_0010, 1, 32'h1000_0200, 0, 32'h1000_0100,   32'h1000_0200, 0, 32'h0,         0);
    add(0, 32'h1000_0018, 0, 1, 1, 0, 32'h1000_0010, 1, 32'h1000_0200, 0, 32'h1000_0100,   32'h1000_0200, 0, 32'h0,         0);
    add(0, 32'h1000_0018, 0, 1, 1, 0, 32'h1000_0010, 1, 32'h1000_0200, 0, 32'h1000_0100,   32'h1000_0200, 0, 32'h0,         0);
    add(0, 32'h1000_0018, 0, 0, 1, 0, 32'h1000_0010, 1, 32'h1000_0200, 0, 32'h1000_0100,   32'h1000_0200, 0, 32'h0,         1);
    add_seq(32'h1000_0200, 32'h1000_0204, 0, 32'h0);
    // One update only: 00 -> 01, target now 0x200.
    add_seq(32'h1000_0010, 32'h1000_0014, 0, 32'h1000_0200);
    add(0, 32'h1000_0014, 0, 0, 1, 0, 32'h1000_0010, 1, 32'h1000_0200, 0, 32'h1000_0200,   32'h1000_0200, 0, 32'h0,         1);
    add_seq(32'h1000_0010, 32'h1000_0200, 1, 32'h1000_0200);
    // JAL at 0x20 -> 0x400: allocate strong, then a correct prediction.
    add_seq(32'h1000_0020, 32'h1000_0024, 0, 32'h0);
    add(0, 32'h1000_0028, 0, 0, 1, 1, 32'h1000_0020, 1, 32'h1000_0400, 0, 32'h0,           32'h1000_0400, 0, 32'h0,         1);
    add_seq(32'h1000_0020, 32'h1000_0400, 1, 32'h1000_0400);
    add(0, 32'h1000_0400, 0, 0, 1, 1, 32'h1000_0020, 1, 32'h1000_0400, 1, 32'h1000_0400,   32'h1000_0404, 0, 32'h0,         0);
    // Saturation at 11: two taken, then one not-taken leaves it at 10.
    add(0, 32'h1000_0404, 0, 0, 1, 0, 32'h1000_0010, 1, 32'h1000_0200, 1, 32'h1000_0200,   32'h1000_0408, 0, 32'h0,         0);
    add(0, 32'h1000_0408, 0, 0, 1, 0, 32'h1000_0010, 1, 32'h1000_0200, 1, 32'h1000_0200,   32'h1000_040c, 0, 32'h0,         0);
    add(0, 32'h1000_040c, 0, 0, 1, 0, 32'h1000_0010, 0, 32'h0,         1, 32'h1000_0200,   32'h1000_0014, 0, 32'h0,         1);
    add_seq(32'h1000_0010, 32'h1000_0200, 1, 32'h1000_0200);
    // Right direction, wrong target.
    add(0, 32'h1000_0014, 0, 0, 1, 0, 32'h1000_0010, 1, 32'h1000_0300, 1, 32'h1000_0200,   32'h1000_0300, 0, 32'h0,         1);
    add_seq(32'h1000_0010, 32'h1000_0300, 1, 32'h1000_0300);
    // PC+4 wraps.
    add_seq(32'hffff_fffc, 32'h0000_0000, 0, 32'h0);

    rst = 1'b1;
    bus.pc_cur = 32'h0; bus.Istall = 1'b0; bus.Dstall = 1'b0; bus.exe_valid = 1'b0;
    bus.exe_is_jump = 1'b0; bus.exe_pc = 32'h0; bus.exe_taken = 1'b0; bus.exe_target = 32'h0;
    bus.exe_pred_taken = 1'b0; bus.exe_pred_target = 32'h0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset during HOLD (Istall): pending redirect to 0x14 must be dropped.
    h = '{rst: 0, pc: 32'h1000_0010, ist: 1, dst: 0, ev: 1, jmp: 0, epc: 32'h1000_0010,
          etk: 0, etgt: 32'h0, eptk: 1, eptgt: 32'h1000_0300,
          x_pcn: 32'h1000_0014, x_ptk: 1, x_ptgt: 32'h1000_0300, x_fl: 0};
    apply_vec(h, "hold_enter");
    apply_vec(h, "hold_wait");
    h.rst = 1'b1; h.x_pcn = 32'h1000_0000; h.x_ptk = 1'b0; h.x_ptgt = 32'h0;
    apply_vec(h, "hold_rst");
    h = '{rst: 0, pc: 32'h0fff_fffc, ist: 0, dst: 0, ev: 0, jmp: 0, epc: 32'h0,
          etk: 0, etgt: 32'h0, eptk: 0, eptgt: 32'h0,
          x_pcn: 32'h1000_0000, x_ptk: 0, x_ptgt: 32'h0, x_fl: 0};
    apply_vec(h, "post_rst");
    h.pc = 32'h1000_0010; h.x_pcn = 32'h1000_0014;
    apply_vec(h, "post_rst_btb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
